// File: rtl/gmii_rx_video_parser.sv
// GMII receive parser: strips preamble/SFD, filters on destination MAC and
// EtherType, extracts the video-line header, packs payload bytes into RGB
// pixels and checks the FCS. Inputs are registered once and every output is
// registered, so results appear two cycles after the byte at the pins.
module gmii_rx_video_parser #(
   parameter logic [47:0] LOCAL_MAC = 48'h00_37_76_00_00_01,
   parameter logic [15:0] ETHERTYPE = 16'h88B5,
   parameter logic [10:0] MAX_PIX   = 11'd1280
) (
   input  logic        gmii_rxclk,
   input  logic        sys_rst,
   input  logic        gmii_rxdv,
   input  logic [7:0]  gmii_rxd,
   output logic        line_start,
   output logic [10:0] line_y,
   output logic [10:0] line_len,
   output logic        pix_valid,
   output logic [23:0] pix_data,
   output logic        frame_done,
   output logic        frame_ok,
   output logic [15:0] drop_cnt
);
   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_DST, S_SRC, S_TYPE, S_HDR, S_PAY, S_TAIL, S_DROP
   } state_t;

   // Reflected-register residue after DST..FCS, expressed in normal bit order.
   localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

   logic        rxdv_reg;
   logic [7:0]  rxd_reg;
   state_t      state_reg, state_next;
   logic [2:0]  cnt_reg, cnt_next;
   logic        loc_ok_reg, loc_ok_next, bc_ok_reg, bc_ok_next;
   logic [10:0] y_reg, y_next;
   logic [2:0]  len_hi_reg, len_hi_next;
   logic [10:0] pix_cnt_reg, pix_cnt_next;
   logic [1:0]  sub_reg, sub_next;
   logic [7:0]  r_reg, r_next, g_reg, g_next;
   logic [2:0]  tail_cnt_reg, tail_cnt_next;
   logic [31:0] crc_reg, crc_next, crc_step, crc_rev;
   logic        line_start_next, pix_valid_next, frame_done_next, frame_ok_next;
   logic [10:0] line_y_next, line_len_next, len_rx;
   logic [23:0] pix_data_next;
   logic [15:0] drop_cnt_next;
   logic        drop_bump, loc_hit, bc_hit, crc_good;
   logic [7:0]  mac_byte [0:7];

   // One byte of the reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320).
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] x;
      x = c;
      for (int i = 0; i < 8; i++)
         x = (x >> 1) ^ ((x[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
      return x;
   endfunction

   genvar gi;
   generate
      // MAC bytes in wire order; slots 6 and 7 are never addressed.
      for (gi = 0; gi < 8; gi++) begin : g_mac
         if (gi < 6) begin : g_byte
            assign mac_byte[gi] = LOCAL_MAC[47-8*gi -: 8];
         end else begin : g_pad
            assign mac_byte[gi] = 8'h00;
         end
      end
      // Bit-reverse the CRC register to compare against the residue constant.
      for (gi = 0; gi < 32; gi++) begin : g_rev
         assign crc_rev[gi] = crc_reg[31-gi];
      end
   endgenerate

   assign crc_step = crc_byte(crc_reg, rxd_reg);
   assign crc_good = (crc_rev == CRC_RESIDUE);
   assign loc_hit  = loc_ok_reg & (rxd_reg == mac_byte[cnt_reg]);
   assign bc_hit   = bc_ok_reg & (rxd_reg == 8'hFF);
   assign len_rx   = {len_hi_reg, rxd_reg};

   // Next-state, datapath and output decode for the frame parser.
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      loc_ok_next     = loc_ok_reg;
      bc_ok_next      = bc_ok_reg;
      y_next          = y_reg;
      len_hi_next     = len_hi_reg;
      pix_cnt_next    = pix_cnt_reg;
      sub_next        = sub_reg;
      r_next          = r_reg;
      g_next          = g_reg;
      tail_cnt_next   = tail_cnt_reg;
      crc_next        = crc_reg;
      line_start_next = 1'b0;
      line_y_next     = line_y;
      line_len_next   = line_len;
      pix_valid_next  = 1'b0;
      pix_data_next   = pix_data;
      frame_done_next = 1'b0;
      frame_ok_next   = 1'b0;
      drop_bump       = 1'b0;
      case (state_reg)
         S_IDLE: if (rxdv_reg && rxd_reg == 8'h55) state_next = S_PRE;
         S_PRE: begin
            if (!rxdv_reg) state_next = S_IDLE;
            else if (rxd_reg == 8'hD5) begin
               state_next  = S_DST;
               cnt_next    = 3'd0;
               loc_ok_next = 1'b1;
               bc_ok_next  = 1'b1;
               crc_next    = 32'hFFFFFFFF;
            end else if (rxd_reg != 8'h55) state_next = S_DROP;
         end
         S_DST, S_SRC, S_TYPE, S_HDR, S_PAY: begin
            if (!rxdv_reg) begin
               // Truncated frame: report it and count it as dropped.
               frame_done_next = 1'b1;
               drop_bump       = 1'b1;
               state_next      = S_IDLE;
            end else begin
               crc_next = crc_step;
               cnt_next = cnt_reg + 3'd1;
               case (state_reg)
                  S_DST: begin
                     loc_ok_next = loc_hit;
                     bc_ok_next  = bc_hit;
                     if (!loc_hit && !bc_hit) state_next = S_DROP;
                     else if (cnt_reg == 3'd5) begin
                        state_next = S_SRC;
                        cnt_next   = 3'd0;
                     end
                  end
                  S_SRC: if (cnt_reg == 3'd5) begin
                     state_next = S_TYPE;
                     cnt_next   = 3'd0;
                  end
                  S_TYPE: begin
                     if (rxd_reg != (cnt_reg[0] ? ETHERTYPE[7:0] : ETHERTYPE[15:8]))
                        state_next = S_DROP;
                     else if (cnt_reg[0]) begin
                        state_next = S_HDR;
                        cnt_next   = 3'd0;
                     end
                  end
                  S_HDR: begin
                     case (cnt_reg[1:0])
                        2'd0: y_next      = {rxd_reg[2:0], y_reg[7:0]};
                        2'd1: y_next      = {y_reg[10:8], rxd_reg};
                        2'd2: len_hi_next = rxd_reg[2:0];
                        default: begin
                           if (len_rx == 11'd0 || len_rx > MAX_PIX) state_next = S_DROP;
                           else begin
                              line_start_next = 1'b1;
                              line_y_next     = y_reg;
                              line_len_next   = len_rx;
                              pix_cnt_next    = 11'd0;
                              sub_next        = 2'd0;
                              state_next      = S_PAY;
                           end
                        end
                     endcase
                  end
                  S_PAY: begin
                     case (sub_reg)
                        2'd0: begin r_next = rxd_reg; sub_next = 2'd1; end
                        2'd1: begin g_next = rxd_reg; sub_next = 2'd2; end
                        default: begin
                           pix_valid_next = 1'b1;
                           pix_data_next  = {r_reg, g_reg, rxd_reg};
                           sub_next       = 2'd0;
                           pix_cnt_next   = pix_cnt_reg + 11'd1;
                           if (pix_cnt_reg + 11'd1 == line_len) begin
                              state_next    = S_TAIL;
                              tail_cnt_next = 3'd0;
                           end
                        end
                     endcase
                  end
                  default: ;
               endcase
            end
         end
         S_TAIL: begin
            if (!rxdv_reg) begin
               frame_done_next = 1'b1;
               frame_ok_next   = crc_good && (tail_cnt_reg >= 3'd4);
               drop_bump       = !frame_ok_next;
               state_next      = S_IDLE;
            end else begin
               crc_next = crc_step;
               if (tail_cnt_reg < 3'd4) tail_cnt_next = tail_cnt_reg + 3'd1;
            end
         end
         S_DROP: if (!rxdv_reg) begin
            drop_bump  = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      drop_cnt_next = (drop_bump && drop_cnt != 16'hFFFF) ? drop_cnt + 16'd1 : drop_cnt;
   end

   // Input capture, parser state and registered outputs.
   always_ff @(posedge gmii_rxclk or posedge sys_rst) begin
      if (sys_rst) begin
         rxdv_reg     <= 1'b0;
         rxd_reg      <= 8'h00;
         state_reg    <= S_IDLE;
         cnt_reg      <= 3'd0;
         loc_ok_reg   <= 1'b0;
         bc_ok_reg    <= 1'b0;
         y_reg        <= 11'd0;
         len_hi_reg   <= 3'd0;
         pix_cnt_reg  <= 11'd0;
         sub_reg      <= 2'd0;
         r_reg        <= 8'h00;
         g_reg        <= 8'h00;
         tail_cnt_reg <= 3'd0;
         crc_reg      <= 32'hFFFFFFFF;
         line_start   <= 1'b0;
         line_y       <= 11'd0;
         line_len     <= 11'd0;
         pix_valid    <= 1'b0;
         pix_data     <= 24'h0;
         frame_done   <= 1'b0;
         frame_ok     <= 1'b0;
         drop_cnt     <= 16'h0;
      end else begin
         rxdv_reg     <= gmii_rxdv;
         rxd_reg      <= gmii_rxd;
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         loc_ok_reg   <= loc_ok_next;
         bc_ok_reg    <= bc_ok_next;
         y_reg        <= y_next;
         len_hi_reg   <= len_hi_next;
         pix_cnt_reg  <= pix_cnt_next;
         sub_reg      <= sub_next;
         r_reg        <= r_next;
         g_reg        <= g_next;
         tail_cnt_reg <= tail_cnt_next;
         crc_reg      <= crc_next;
         line_start   <= line_start_next;
         line_y       <= line_y_next;
         line_len     <= line_len_next;
         pix_valid    <= pix_valid_next;
         pix_data     <= pix_data_next;
         frame_done   <= frame_done_next;
         frame_ok     <= frame_ok_next;
         drop_cnt     <= drop_cnt_next;
      end
   end
endmodule
